depth_neighbor_fetch: RTL and testbench

Raster-order depth-stream front end for the normal-computation stage. Buffers one line of depth, then for every pixel (u,v) presents the depth triple d(u,v), d(u+1,v), d(u,v+1) together with the pixel index, one triple per cycle. This is the exact input set the downstream normal computer consumes. The block sits directly between the depth-frame source and the normal computer and has no downstream backpressure, because the normal computer is a fixed-latency pipeline.

---
 rtl/depth_neighbor_fetch.sv | 171 +++++++++++++++++
 tb/tb_depth_neighbor_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/depth_neighbor_fetch.sv
// depth_neighbor_fetch: raster depth-stream front end for normal computation.
// Buffers one depth line and emits d(u,v), d(u+1,v), d(u,v+1) per pixel.
// Optional ingress range mask: define DEPTH_NEIGHBOR_RANGE_MASK_EN.
module depth_neighbor_fetch #(
    parameter int unsigned IMG_WID  = 640,  // MAX_SRC_WID
    parameter int unsigned IMG_HGT  = 480,  // MAX_SRC_HGT
    parameter int unsigned DEPTH_BW = 16,   // DATA_DEPTH_BW
    parameter int unsigned U_BW     = 10,   // H_SIZE_BW
    parameter int unsigned V_BW     = 9     // V_SIZE_BW
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic                i_frame_start,
    input  logic [DEPTH_BW-1:0] i_depth,
    output logic                o_ready,
    output logic                o_valid,
    output logic [U_BW-1:0]     o_u,
    output logic [V_BW-1:0]     o_v,
    output logic [DEPTH_BW-1:0] o_depth_0,
    output logic [DEPTH_BW-1:0] o_depth_u,
    output logic [DEPTH_BW-1:0] o_depth_v,
    output logic                o_frame_done
);

    localparam int unsigned     AW     = (IMG_WID > 1) ? $clog2(IMG_WID) : 1;
    localparam logic [U_BW-1:0] X_LAST = U_BW'(IMG_WID - 1);
    localparam logic [V_BW-1:0] Y_LAST = V_BW'(IMG_HGT - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

    state_t              state, state_n;
    logic [U_BW-1:0]     x, x_n, f, f_n;
    logic [V_BW-1:0]     y, y_n;
    logic [DEPTH_BW-1:0] lb [IMG_WID];
    logic [DEPTH_BW-1:0] din;

    logic                accept, restart, wr_en;
    logic [U_BW-1:0]     pos_x, rd_x;
    logic [V_BW-1:0]     pos_y;
    logic [AW-1:0]       wr_idx, rd_idx, nxt_idx;
    logic [DEPTH_BW-1:0] rd_d0, rd_du;

    logic                valid_n, done_n;
    logic [U_BW-1:0]     u_n;
    logic [V_BW-1:0]     v_n;
    logic [DEPTH_BW-1:0] d0_n, du_n, dv_n;

`ifdef DEPTH_NEIGHBOR_RANGE_MASK_EN
    localparam logic [DEPTH_BW-1:0] MIN_DEPTH = DEPTH_BW'(0);
    localparam logic [DEPTH_BW-1:0] MAX_DEPTH = DEPTH_BW'(20000);
    // Out-of-range depths are zeroed before they reach the line buffer
    assign din = ((i_depth > MIN_DEPTH) && (i_depth < MAX_DEPTH)) ? i_depth : '0;
`else
    assign din = i_depth;
`endif

    // Input is held off only while flushing the last row or in reset
    assign o_ready = !i_rst && (state != FLUSH);

    // Next-state, counters, line-buffer write and next output values
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        f_n     = f;
        wr_en   = 1'b0;
        valid_n = 1'b0;
        done_n  = 1'b0;
        u_n     = '0;
        v_n     = '0;
        d0_n    = '0;
        du_n    = '0;
        dv_n    = '0;

        restart = i_valid && i_frame_start && (state != FLUSH);
        accept  = i_valid && (state != FLUSH) && ((state != IDLE) || i_frame_start);
        pos_x   = restart ? '0 : x;
        pos_y   = restart ? '0 : y;
        rd_x    = (state == FLUSH) ? f : pos_x;
        wr_idx  = AW'(pos_x);
        rd_idx  = AW'(rd_x);
        nxt_idx = (rd_x == X_LAST) ? '0 : AW'(rd_x + U_BW'(1));
        rd_d0   = lb[rd_idx];
        rd_du   = (rd_x == X_LAST) ? '0 : lb[nxt_idx];

        if (accept) begin
            wr_en = 1'b1;
            if ((state == STREAM) && !restart) begin
                valid_n = 1'b1;
                u_n     = pos_x;
                v_n     = pos_y - V_BW'(1);
                d0_n    = rd_d0;
                du_n    = rd_du;
                dv_n    = din;
            end
            if (pos_x == X_LAST) begin
                x_n = '0;
                if (pos_y == Y_LAST) begin
                    y_n     = '0;
                    f_n     = '0;
                    state_n = FLUSH;
                end else begin
                    y_n     = pos_y + V_BW'(1);
                    state_n = STREAM;
                end
            end else begin
                x_n     = pos_x + U_BW'(1);
                y_n     = pos_y;
                state_n = (pos_y == '0) ? FILL : STREAM;
            end
        end else if (state == FLUSH) begin
            valid_n = 1'b1;
            u_n     = f;
            v_n     = Y_LAST;
            d0_n    = rd_d0;
            du_n    = rd_du;
            if (f == X_LAST) begin
                done_n  = 1'b1;
                f_n     = '0;
                state_n = IDLE;
            end else begin
                f_n = f + U_BW'(1);
            end
        end
    end

    // State and position counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            f     <= '0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            f     <= f_n;
        end
    end

    // Registered output triple
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_u          <= '0;
            o_v          <= '0;
            o_depth_0    <= '0;
            o_depth_u    <= '0;
            o_depth_v    <= '0;
        end else begin
            o_valid      <= valid_n;
            o_frame_done <= done_n;
            o_u          <= u_n;
            o_v          <= v_n;
            o_depth_0    <= d0_n;
            o_depth_u    <= du_n;
            o_depth_v    <= dv_n;
        end
    end

    // Line buffer: read-before-write, contents rewritten by row 0 of each frame
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            lb[wr_idx] <= din;
        end
    end

endmodule

// File: tb/tb_depth_neighbor_fetch.sv
// Self-checking bench for depth_neighbor_fetch (IMG_WID=4, IMG_HGT=3).
// The expected triples come from a whole-image model, not a line-buffer copy.
module tb_depth_neighbor_fetch;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int DBW = 16;
    localparam int UBW = 10;
    localparam int VBW = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic           fs;
    logic [DBW-1:0] depth;
    logic           o_ready, o_valid, o_frame_done;
    logic [UBW-1:0] o_u;
    logic [VBW-1:0] o_v;
    logic [DBW-1:0] o_depth_0, o_depth_u, o_depth_v;

    typedef struct packed {
        logic [UBW-1:0] u;
        logic [VBW-1:0] v;
        logic [DBW-1:0] d0;
        logic [DBW-1:0] du;
        logic [DBW-1:0] dv;
        logic           done;
    } exp_t;

    exp_t           q[$];
    int             checks   = 0;
    int             failures = 0;
    int             mstate   = 0;   // 0 idle, 1 fill/stream, 2 flush
    int             mx = 0, my = 0, mf = 0;
    logic [DBW-1:0] img [H][W];
    bit             override_en = 1'b0;

    depth_neighbor_fetch #(
        .IMG_WID (W),
        .IMG_HGT (H),
        .DEPTH_BW(DBW),
        .U_BW    (UBW),
        .V_BW    (VBW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_frame_start(fs),
        .i_depth      (depth),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_u          (o_u),
        .o_v          (o_v),
        .o_depth_0    (o_depth_0),
        .o_depth_u    (o_depth_u),
        .o_depth_v    (o_depth_v),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DBW-1:0] mask(input logic [DBW-1:0] d);
`ifdef DEPTH_NEIGHBOR_RANGE_MASK_EN
        return ((d > 16'd0) && (d < 16'd20000)) ? d : 16'd0;
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model, push/pop the scoreboard
    task automatic step(input logic v, input logic f_s, input logic [DBW-1:0] d);
        bit             exp_v;
        exp_t           e;
        logic [DBW-1:0] md;
        exp_v = 1'b0;
        e     = '0;
        md    = mask(d);
        valid = v;
        fs    = f_s;
        depth = d;
        check("ready", 128'(o_ready), 128'(mstate != 2));
        if (v && (mstate != 2) && (f_s || (mstate != 0))) begin
            if (f_s) begin
                mx = 0; my = 0; mstate = 1;
            end
            img[my][mx] = md;
            if (my > 0) begin
                e.u  = UBW'(mx);
                e.v  = VBW'(my - 1);
                e.d0 = img[my-1][mx];
                if (mx < W - 1) e.du = img[my-1][mx+1];
                e.dv = md;
                q.push_back(e);
                exp_v = 1'b1;
            end
            if (mx == W - 1) begin
                mx = 0;
                if (my == H - 1) begin
                    mstate = 2; mf = 0;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end else if (mstate == 2) begin
            e.u  = UBW'(mf);
            e.v  = VBW'(H - 1);
            e.d0 = img[H-1][mf];
            if (mf < W - 1) e.du = img[H-1][mf+1];
            e.done = (mf == W - 1);
            q.push_back(e);
            exp_v = 1'b1;
            if (mf == W - 1) mstate = 0;
            else mf++;
        end
        @(posedge clk);
        #1;
        check("valid", 128'(o_valid), 128'(exp_v));
        if (exp_v && (q.size() > 0)) begin
            e = q.pop_front();
            check("triple", 128'({o_u, o_v, o_depth_0, o_depth_u, o_depth_v, o_frame_done}), 128'(e));
        end
    endtask

    // Pixel at the position the model says it will land, optional random gaps first
    task automatic send_pixel(input logic f_s, input int gap_pct);
        int             px, py, n;
        logic [DBW-1:0] val;
        n = 0;
        while ((gap_pct > 0) && ($urandom_range(99) < gap_pct) && (n < 20)) begin
            step(1'b0, 1'b0, 16'hdead);
            n++;
        end
        px  = f_s ? 0 : mx;
        py  = f_s ? 0 : my;
        val = (override_en && (px == 1) && (py == 1)) ? 16'd25000 : DBW'(10 * py + px + 1);
        step(1'b1, f_s, val);
    endtask

    // Full frame plus flush; hold=1 presents a held frame-start pixel during flush
    task automatic run_frame(input int gap_pct, input logic hold);
        int n;
        send_pixel(1'b1, gap_pct);
        for (int i = 1; i < W * H; i++) send_pixel(1'b0, gap_pct);
        n = 0;
        while ((mstate == 2) && (n < W + 2)) begin
            step(hold, hold, 16'd1);
            n++;
        end
        check("flush_end", 128'(mstate), 128'(0));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        fs    = 1'b0;
        depth = '0;
        #1;
        check("rst_ready", 128'(o_ready), 128'(0));
        @(posedge clk);
        #1;
        check("rst_outs", 128'({o_valid, o_frame_done, o_u, o_v, o_depth_0, o_depth_u, o_depth_v}), 128'(0));
        rst = 1'b0;
        #1;
        check("rel_ready", 128'(o_ready), 128'(1));
        mstate = 0; mx = 0; my = 0; mf = 0;
        q.delete();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; fs = 1'b0; depth = '0;
        @(posedge clk);
        do_reset();

        // Full frame, no gaps
        run_frame(0, 1'b0);

        // Same frame with 50% input gaps
        run_frame(50, 1'b0);

        // Stray pixels in IDLE are dropped
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd99);
        run_frame(0, 1'b0);

        // Restart at what would be pixel (1,2)
        send_pixel(1'b1, 0);
        for (int i = 1; i < 9; i++) send_pixel(1'b0, 0);
        run_frame(0, 1'b0);

        // Reset asserted when flush f=1 would be issued
        send_pixel(1'b1, 0);
        for (int i = 1; i < W * H; i++) send_pixel(1'b0, 0);
        step(1'b0, 1'b0, 16'd0);
        check("pre_rst_f", 128'(mf), 128'(1));
        do_reset();
        run_frame(0, 1'b1);
        run_frame(0, 1'b0);

        // Out-of-range depth at (1,1)
        override_en = 1'b1;
        run_frame(0, 1'b0);
        override_en = 1'b0;

        check("queue_empty", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
